// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative IEEE-754 divider.
package fp_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL,
    DIV,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } cls_t;

  localparam int NUM_FLAGS = 5;
  localparam int FLG_INV   = 4;
  localparam int FLG_DZ    = 3;
  localparam int FLG_OF    = 2;
  localparam int FLG_UF    = 1;
  localparam int FLG_NX    = 0;

endpackage

// File: rtl/fp_div_special.sv
// Operand classifier and special-case result/flag generator (purely combinational).
module fp_div_special
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int DATA_WIDTH = 1 + EXP_W + FRAC_W
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  is_special,
  output logic [DATA_WIDTH-1:0] result,
  output logic [NUM_FLAGS-1:0]  flags
);

  cls_t cls_a;
  cls_t cls_b;
  logic sign;
  logic a_nan;
  logic b_nan;
  logic [DATA_WIDTH-1:0] qnan;
  logic [DATA_WIDTH-1:0] inf_res;
  logic [DATA_WIDTH-1:0] zero_res;

  // Subnormals are flushed: any zero exponent classifies as ZERO.
  function automatic cls_t classify(input logic [DATA_WIDTH-2:0] mag);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    cls_t c;
    e = mag[DATA_WIDTH-2 -: EXP_W];
    f = mag[FRAC_W-1:0];
    if (e == '0)
      c = ZERO;
    else if (&e) begin
      if (f == '0)
        c = INF;
      else if (f[FRAC_W-1])
        c = QNAN;
      else
        c = SNAN;
    end else
      c = NORM;
    return c;
  endfunction

  always_comb begin
    cls_a    = classify(a[DATA_WIDTH-2:0]);
    cls_b    = classify(b[DATA_WIDTH-2:0]);
    sign     = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
    a_nan    = (cls_a == QNAN) || (cls_a == SNAN);
    b_nan    = (cls_b == QNAN) || (cls_b == SNAN);
    qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    inf_res  = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    zero_res = {sign, {(DATA_WIDTH-1){1'b0}}};

    is_special = 1'b1;
    result     = '0;
    flags      = '0;

    if (a_nan || b_nan) begin
      result         = qnan;
      flags[FLG_INV] = (cls_a == SNAN) || (cls_b == SNAN);
    end else if (((cls_a == ZERO) && (cls_b == ZERO)) ||
                 ((cls_a == INF) && (cls_b == INF))) begin
      result         = qnan;
      flags[FLG_INV] = 1'b1;
    end else if ((cls_a == NORM) && (cls_b == ZERO)) begin
      result        = inf_res;
      flags[FLG_DZ] = 1'b1;
    end else if (cls_a == INF) begin
      result = inf_res;
    end else if ((cls_b == INF) || (cls_a == ZERO)) begin
      result = zero_res;
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative restoring IEEE-754 divider: one quotient bit per cycle, RNE rounding,
// flush-to-zero on subnormal inputs and results.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  localparam int DATA_WIDTH = 1 + EXP_W + FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [NUM_FLAGS-1:0]  out_flags,
  output state_t                dbg_state
);

  localparam int N  = FRAC_W + 3;
  localparam int CW = $clog2(N + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is 1 only in IDLE; out_valid is 1 only in DONE, where out/out_flags stay
  // frozen until the consumer raises out_ready.
  state_t state;
  state_t state_nx;

  logic                  sign_r;
  logic signed [EW-1:0]  e_r;
  logic [FRAC_W:0]       mb_r;
  logic [FRAC_W+1:0]     rem_r;
  logic [N-1:0]          q_r;
  logic [CW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] spec_res_r;
  logic [NUM_FLAGS-1:0]  spec_flags_r;
  logic [DATA_WIDTH-1:0] out_r;
  logic [NUM_FLAGS-1:0]  flags_r;

  logic                  is_special;
  logic [DATA_WIDTH-1:0] spec_res;
  logic [NUM_FLAGS-1:0]  spec_flags;

  fp_div_special #(
    .EXP_W (EXP_W),
    .FRAC_W(FRAC_W)
  ) u_special (
    .a         (in1),
    .b         (in2),
    .is_special(is_special),
    .result    (spec_res),
    .flags     (spec_flags)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = is_special ? SPECIAL : DIV;
      SPECIAL: state_nx = DONE;
      DIV:     if (cnt_r == '0) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One restoring step; R stays below 2*mb so the shifted-out MSB is always 0.
  logic              q_bit;
  logic [FRAC_W+1:0] rem_sub;
  logic [FRAC_W+1:0] rem_next;

  always_comb begin
    q_bit    = rem_r >= {1'b0, mb_r};
    rem_sub  = q_bit ? (rem_r - {1'b0, mb_r}) : rem_r;
    rem_next = rem_sub << 1;
  end

  logic [FRAC_W:0]       sig_n;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [FRAC_W+1:0]     sig_inc;
  logic [FRAC_W-1:0]     frac_fin;
  logic signed [EW-1:0]  e_n;
  logic signed [EW-1:0]  e_fin;
  logic [DATA_WIDTH-1:0] rnd_res;
  logic [NUM_FLAGS-1:0]  rnd_flags;

  always_comb begin
    if (q_r[N-1]) begin
      sig_n  = q_r[N-1:2];
      guard  = q_r[1];
      sticky = q_r[0] | (|rem_r);
      e_n    = e_r;
    end else begin
      sig_n  = q_r[N-2:1];
      guard  = q_r[0];
      sticky = |rem_r;
      e_n    = e_r - E_ONE;
    end
    inc     = guard & (sticky | sig_n[0]);
    sig_inc = {1'b0, sig_n} + (FRAC_W+2)'(inc);
    // A carry out of the significand leaves 10...0, so the fraction is just the shift.
    if (sig_inc[FRAC_W+1]) begin
      frac_fin = sig_inc[FRAC_W:1];
      e_fin    = e_n + E_ONE;
    end else begin
      frac_fin = sig_inc[FRAC_W-1:0];
      e_fin    = e_n;
    end

    rnd_flags = '0;
    if (e_fin >= E_MAX) begin
      rnd_res           = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rnd_flags[FLG_OF] = 1'b1;
      rnd_flags[FLG_NX] = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      rnd_res           = {sign_r, {(DATA_WIDTH-1){1'b0}}};
      rnd_flags[FLG_UF] = 1'b1;
      rnd_flags[FLG_NX] = 1'b1;
    end else begin
      rnd_res           = {sign_r, e_fin[EXP_W-1:0], frac_fin};
      rnd_flags[FLG_NX] = guard | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r       <= 1'b0;
      e_r          <= '0;
      mb_r         <= '0;
      rem_r        <= '0;
      q_r          <= '0;
      cnt_r        <= '0;
      spec_res_r   <= '0;
      spec_flags_r <= '0;
      out_r        <= '0;
      flags_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r       <= in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];
            e_r          <= EW'({2'b00, in1[DATA_WIDTH-2 -: EXP_W]})
                          - EW'({2'b00, in2[DATA_WIDTH-2 -: EXP_W]}) + E_BIAS;
            mb_r         <= {1'b1, in2[FRAC_W-1:0]};
            rem_r        <= {2'b01, in1[FRAC_W-1:0]};
            q_r          <= '0;
            cnt_r        <= CW'(N - 1);
            spec_res_r   <= spec_res;
            spec_flags_r <= spec_flags;
          end
        end
        DIV: begin
          rem_r <= rem_next;
          q_r   <= {q_r[N-2:0], q_bit};
          if (cnt_r != '0) cnt_r <= cnt_r - CW'(1);
        end
        SPECIAL: begin
          out_r   <= spec_res_r;
          flags_r <= spec_flags_r;
        end
        ROUND: begin
          out_r   <= rnd_res;
          flags_r <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_r;
  assign out_flags = flags_r;
  assign dbg_state = state;

endmodule
